ntt_dit_scheduler: RTL and testbench
====================================

Name: ntt_dit_scheduler

Overview:
- Issue-side controller for the radix-2 DIT butterfly datapath in an iterative in-place NTT.
- Walks all log2(N) stages and emits one butterfly per cycle: read addresses for the A/B pair, the twiddle index and the butterfly mode/swap controls.
- Delays the pair addresses by the fixed read+butterfly latency and presents them as write-back addresses with write enables.
- Sits between the coefficient RAM / twiddle ROM and the butterfly datapath; a top-level start/done handshake drives it.

Parameters:
- N_LOG, 8, log2 of transform length N; legal range 2..12.
- RD_LATENCY, 1, cycles from rd_en to RAM data at the butterfly inputs.
- BF_LATENCY, `INTMUL_DELAY+`MODRED_DELAY+2, cycles from butterfly inputs to A_out/B_out.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; starts a transform when idle.
- stall  in  1  holds issue; in-flight operations continue.
- rd_en  out  1  read strobe for both RAM ports.
- rd_addr_a  out  N_LOG  A read address.
- rd_addr_b  out  N_LOG  B read address.
- tw_index  out  N_LOG  twiddle ROM index, aligned with rd_en.
- bf_mode  out  1  butterfly mode: 0 = butterfly, 1 = multiply.
- bf_swap  out  1  multiply A instead of B.
- wr_en_a  out  1  write strobe for A_out.
- wr_en_b  out  1  write strobe for B_out.
- wr_addr_a  out  N_LOG  A write address.
- wr_addr_b  out  N_LOG  B write address.
- busy  out  1  high from the first issue cycle through the final drain cycle.
- done  out  1  one-cycle pulse on completion.

Behaviour:
- D = RD_LATENCY + BF_LATENCY.
- Reset: every output is 0; FSM goes to IDLE; counters and the address pipe are cleared. Reset mid-transform abandons the transform and produces no done.
- IDLE: start=1 sampled at edge k → ISSUE. First rd_en is in cycle k+1. start while busy is ignored.
- ISSUE: stage s (0..N_LOG-1), half = 2^s, group g, offset j (0..half-1).
  - rd_addr_a = g*2*half + j; rd_addr_b = rd_addr_a + half.
  - tw_index = j*(N/(2*half)), MSB = 0 (butterfly table region).
  - bf_mode = 0, bf_swap = 0.
  - Order: j increments fastest, then g. There are N/2 issues per stage.
  - stall=1: rd_en = 0, counters hold, a bubble enters the pipe.
- DRAIN: entered after the last issue of a stage; lasts D cycles, counting non-stalled and stalled cycles alike. This removes the read-after-write hazard: the next stage's first read occurs 1 cycle after the previous stage's last write.
  - Then: next stage → ISSUE, or last stage → DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- Write-back: wr_en_a/b and wr_addr_a/b equal rd_en and rd_addr_a/b delayed exactly D cycles, including bubbles.
- Overflow: counters never wrap past stage N_LOG-1; address arithmetic is modulo 2^N_LOG but cannot overflow by construction.
- Input data is bit-reversed order; output is natural order.
- Total cycles from the start edge to done: N_LOG*(N/2 + D) + 1 + number of stall cycles during ISSUE.

Optional Feature:
- Macro: NTT_POSTMUL_EN.
- Enabled: after the final stage drain, a POSTMUL pass runs, then its own drain of D cycles, then DONE.
  - N issues, k = 0..N-1: rd_addr_a = rd_addr_b = k, tw_index = N/2 + k/2, bf_mode = 1, bf_swap = 1.
  - Write-back: wr_en_a only; wr_en_b stays 0.
  - The twiddle ROM upper region holds the per-coefficient post-multiply factors (e.g. N^-1 times twist), packed two per index: even k in the low word, odd k in the high word, selected by the RAM wrapper.
  - Total cycles increase by N + D.
- Disabled: no POSTMUL state, the tw_index MSB is constant 0, and bf_mode/bf_swap are tied to 0.

Decomposition:
- Shared package/defines: FSM state encodings (IDLE, ISSUE, DRAIN, POSTMUL, DONE) and the D latency expression.
- Sub-module ntt_addr_pipe: a D-deep shift register carrying {rd_en, pair flag, rd_addr_a, rd_addr_b}, with asynchronous active-low clear.

Test Plan:
- N_LOG=3, BF_LATENCY=3, RD_LATENCY=1 (D=4), start at edge 0 → issue pairs as follows; done at cycle 25; busy high in cycles 1..24.
  - Stage 0, cycles 1-4: (0,1)(2,3)(4,5)(6,7), tw 0,0,0,0.
  - Stage 1, cycles 9-12: (0,2)(1,3)(4,6)(5,7), tw 0,2,0,2.
  - Stage 2, cycles 17-20: (0,4)(1,5)(2,6)(3,7), tw 0,1,2,3.
- Same config → wr_en_a/wr_addr_a equal rd_en/rd_addr_a shifted exactly 4 cycles; the first write is (0,1) in cycle 5; the last write of stage 0 is in cycle 8, one cycle before stage 1's first read in cycle 9.
- stall=1 in cycles 2-3 → stage 0 issues in cycles 1,4,5,6; write-back bubbles land in cycles 6-7; done is in cycle 27.
- reset=0 pulsed in cycle 10 → all outputs 0 immediately with no done pulse; a subsequent start restarts from stage 0, pair (0,1).
- start re-pulsed in cycle 5 while busy → no effect on the address sequence or done timing.
- NTT_POSTMUL_EN defined, same config → 8 multiply issues in cycles 25-32 with addresses 0..7, tw_index 4,4,5,5,6,6,7,7 and bf_mode=bf_swap=1; wr_en_b stays 0; done in cycle 37.

Source files
------------

// File: rtl/ntt_dit_scheduler_pkg.sv
// rtl/ntt_dit_scheduler_pkg.sv - shared FSM encoding and latency helpers for the NTT DIT scheduler
// Purpose: state encoding and the D = RD_LATENCY + BF_LATENCY expression.
// Ports: none (package). Defaults for the datapath latency macros live here.
`ifndef INTMUL_DELAY
`define INTMUL_DELAY 1
`endif
`ifndef MODRED_DELAY
`define MODRED_DELAY 0
`endif

package ntt_dit_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_POSTMUL = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Read-to-writeback distance of the butterfly path.
  function automatic int d_latency(int rd_latency, int bf_latency);
    return rd_latency + bf_latency;
  endfunction

endpackage

// File: rtl/ntt_dit_scheduler_if.sv
// rtl/ntt_dit_scheduler_if.sv - issue/write-back bundle between scheduler and butterfly datapath
// Purpose: groups start/stall control, read issue, write-back and status signals.
// Ports (master = scheduler side):
//   in : start, stall
//   out: rd_en, rd_addr_a, rd_addr_b, tw_index, bf_mode, bf_swap,
//        wr_en_a, wr_en_b, wr_addr_a, wr_addr_b, busy, done
interface ntt_dit_scheduler_if #(
  parameter int N_LOG = 8
) ();
  logic             start;
  logic             stall;
  logic             rd_en;
  logic [N_LOG-1:0] rd_addr_a;
  logic [N_LOG-1:0] rd_addr_b;
  logic [N_LOG-1:0] tw_index;
  logic             bf_mode;
  logic             bf_swap;
  logic             wr_en_a;
  logic             wr_en_b;
  logic [N_LOG-1:0] wr_addr_a;
  logic [N_LOG-1:0] wr_addr_b;
  logic             busy;
  logic             done;

  modport master (
    input  start, stall,
    output rd_en, rd_addr_a, rd_addr_b, tw_index, bf_mode, bf_swap,
           wr_en_a, wr_en_b, wr_addr_a, wr_addr_b, busy, done
  );

  modport slave (
    output start, stall,
    input  rd_en, rd_addr_a, rd_addr_b, tw_index, bf_mode, bf_swap,
           wr_en_a, wr_en_b, wr_addr_a, wr_addr_b, busy, done
  );
endinterface

// File: rtl/ntt_dit_scheduler_addr_pipe.sv
// rtl/ntt_dit_scheduler_addr_pipe.sv - fixed-depth delay line turning read issues into write-backs
// Purpose: DEPTH-stage shift register carrying {en, pair, addr_a, addr_b}.
// Ports:
//   clk, reset (async, active-low clear)
//   en_i, pair_i, addr_a_i, addr_b_i : issue-side values
//   en_o, pair_o, addr_a_o, addr_b_o : same values DEPTH cycles later
module ntt_addr_pipe #(
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en_i,
  input  logic          pair_i,
  input  logic [AW-1:0] addr_a_i,
  input  logic [AW-1:0] addr_b_i,
  output logic          en_o,
  output logic          pair_o,
  output logic [AW-1:0] addr_a_o,
  output logic [AW-1:0] addr_b_o
);
  localparam int W = 2 + 2 * AW;

  logic [W-1:0] pipe_q [DEPTH];

  // Bubbles (en=0) travel through the line like real entries so the
  // write-back timing never depends on stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= {en_i, pair_i, addr_a_i, addr_b_i};
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign {en_o, pair_o, addr_a_o, addr_b_o} = pipe_q[DEPTH-1];
endmodule

// File: rtl/ntt_dit_scheduler.sv
// rtl/ntt_dit_scheduler.sv - issue-side controller for an iterative in-place radix-2 DIT NTT
// Purpose: walks N_LOG stages issuing one butterfly per cycle, drains D cycles
// between stages, and replays pair addresses D cycles later as write-backs.
// Optional macro NTT_POSTMUL_EN adds a final per-coefficient multiply pass.
// Ports:
//   clk   : clock
//   reset : asynchronous active-low reset
//   bus   : ntt_dit_scheduler_if.master (start/stall in; issue, write-back, busy/done out)
module ntt_dit_scheduler
  import ntt_dit_scheduler_pkg::*;
#(
  parameter int N_LOG      = 8,
  parameter int RD_LATENCY = 1,
  parameter int BF_LATENCY = `INTMUL_DELAY + `MODRED_DELAY + 2
) (
  input  logic                   clk,
  input  logic                   reset,
  ntt_dit_scheduler_if.master    bus
);
  localparam int D      = d_latency(RD_LATENCY, BF_LATENCY);
  localparam int HALF_N = (1 << N_LOG) / 2;
  localparam int DW     = $clog2(D + 1);

  state_e           state_q, state_d;
  logic [3:0]       stage_q, stage_d;
  logic [N_LOG-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    drain_q, drain_d;
`ifdef NTT_POSTMUL_EN
  logic             post_q, post_d;
`endif

  logic             rd_en_c, pair_c, mode_c;
  logic [N_LOG-1:0] addr_a_c, addr_b_c, tw_c;
  logic             busy_c, done_c;

  // Butterfly address generation: inserting a zero bit at position s of the
  // issue count gives g*2*half + j with j in the low s bits.
  logic [N_LOG-1:0] half, mask, lo, hi, bf_a, bf_b, bf_tw;
  assign half  = N_LOG'(1) << stage_q;
  assign mask  = half - N_LOG'(1);
  assign lo    = cnt_q & mask;
  assign hi    = cnt_q & ~mask;
  assign bf_a  = (hi << 1) | lo;
  assign bf_b  = bf_a | half;
  assign bf_tw = lo << (4'(N_LOG - 1) - stage_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      cnt_q   <= '0;
      drain_q <= '0;
`ifdef NTT_POSTMUL_EN
      post_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
`ifdef NTT_POSTMUL_EN
      post_q  <= post_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    cnt_d    = cnt_q;
    drain_d  = drain_q;
`ifdef NTT_POSTMUL_EN
    post_d   = post_q;
`endif
    rd_en_c  = 1'b0;
    pair_c   = 1'b0;
    mode_c   = 1'b0;
    addr_a_c = '0;
    addr_b_c = '0;
    tw_c     = '0;
    busy_c   = 1'b0;
    done_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_ISSUE;
          stage_d = '0;
          cnt_d   = '0;
          drain_d = '0;
`ifdef NTT_POSTMUL_EN
          post_d  = 1'b0;
`endif
        end
      end
      ST_ISSUE: begin
        busy_c = 1'b1;
        if (!bus.stall) begin
          rd_en_c  = 1'b1;
          pair_c   = 1'b1;
          addr_a_c = bf_a;
          addr_b_c = bf_b;
          tw_c     = bf_tw;
          if (cnt_q == N_LOG'(HALF_N - 1)) begin
            cnt_d   = '0;
            drain_d = '0;
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + N_LOG'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Drain time is wall-clock: stall does not extend it.
        busy_c = 1'b1;
        if (drain_q == DW'(D - 1)) begin
          drain_d = '0;
`ifdef NTT_POSTMUL_EN
          if (post_q) begin
            state_d = ST_DONE;
          end else if (stage_q == 4'(N_LOG - 1)) begin
            state_d = ST_POSTMUL;
          end else begin
            stage_d = stage_q + 4'd1;
            state_d = ST_ISSUE;
          end
`else
          if (stage_q == 4'(N_LOG - 1)) begin
            state_d = ST_DONE;
          end else begin
            stage_d = stage_q + 4'd1;
            state_d = ST_ISSUE;
          end
`endif
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
`ifdef NTT_POSTMUL_EN
      ST_POSTMUL: begin
        busy_c = 1'b1;
        if (!bus.stall) begin
          rd_en_c  = 1'b1;
          mode_c   = 1'b1;
          addr_a_c = cnt_q;
          addr_b_c = cnt_q;
          // Upper ROM half, two post-multiply factors per index.
          tw_c     = {1'b1, cnt_q[N_LOG-1:1]};
          if (&cnt_q) begin
            cnt_d   = '0;
            drain_d = '0;
            post_d  = 1'b1;
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + N_LOG'(1);
          end
        end
      end
`endif
      ST_DONE: begin
        done_c  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.rd_en     = rd_en_c;
  assign bus.rd_addr_a = addr_a_c;
  assign bus.rd_addr_b = addr_b_c;
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
`ifdef NTT_POSTMUL_EN
  assign bus.tw_index  = tw_c;
  assign bus.bf_mode   = mode_c;
  assign bus.bf_swap   = mode_c;
`else
  assign bus.tw_index  = {1'b0, tw_c[N_LOG-2:0]};
  assign bus.bf_mode   = 1'b0;
  assign bus.bf_swap   = 1'b0;
  logic unused_c;
  assign unused_c = mode_c ^ tw_c[N_LOG-1];
`endif

  // pair_c is only set on butterfly issues, so it doubles as the B write enable.
  ntt_addr_pipe #(
    .DEPTH (D),
    .AW    (N_LOG)
  ) u_addr_pipe (
    .clk      (clk),
    .reset    (reset),
    .en_i     (rd_en_c),
    .pair_i   (pair_c),
    .addr_a_i (addr_a_c),
    .addr_b_i (addr_b_c),
    .en_o     (bus.wr_en_a),
    .pair_o   (bus.wr_en_b),
    .addr_a_o (bus.wr_addr_a),
    .addr_b_o (bus.wr_addr_b)
  );
endmodule

// File: tb/tb_ntt_dit_scheduler.sv
// tb/tb_ntt_dit_scheduler.sv - self-checking bench for ntt_dit_scheduler against a schedule model
module tb_ntt_dit_scheduler;
  localparam int N_LOG = 3;
  localparam int RD    = 1;
  localparam int BF    = 3;
  localparam int D     = RD + BF;
  localparam int N     = 1 << N_LOG;
  localparam int MAXC  = 256;
`ifdef NTT_POSTMUL_EN
  localparam int PM_EXTRA = N + D;
`else
  localparam int PM_EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ntt_dit_scheduler_if #(.N_LOG(N_LOG)) bus ();

  ntt_dit_scheduler #(
    .N_LOG      (N_LOG),
    .RD_LATENCY (RD),
    .BF_LATENCY (BF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  bit             stall_pat [MAXC];
  bit             e_en      [MAXC];
  bit             e_pair    [MAXC];
  bit             e_mode    [MAXC];
  logic [N_LOG-1:0] e_a     [MAXC];
  logic [N_LOG-1:0] e_b     [MAXC];
  logic [N_LOG-1:0] e_tw    [MAXC];

  // Schedule model: issues are listed in order and placed in the first
  // non-stalled cycle; each pass is followed by D drain cycles.
  task automatic build_model(output int done_c);
    int c;
    for (int i = 0; i < MAXC; i++) begin
      e_en[i] = 0; e_pair[i] = 0; e_mode[i] = 0; e_a[i] = '0; e_b[i] = '0; e_tw[i] = '0;
    end
    c = 1;
    for (int s = 0; s < N_LOG; s++) begin
      int half;
      half = 1 << s;
      for (int g = 0; g < N / (2 * half); g++) begin
        for (int j = 0; j < half; j++) begin
          while (stall_pat[c] && c < MAXC - 1) c++;
          e_en[c] = 1; e_pair[c] = 1;
          e_a[c]  = N_LOG'(g * 2 * half + j);
          e_b[c]  = N_LOG'(g * 2 * half + j + half);
          e_tw[c] = N_LOG'(j * (N / (2 * half)));
          c++;
        end
      end
      c += D;
    end
`ifdef NTT_POSTMUL_EN
    for (int k = 0; k < N; k++) begin
      while (stall_pat[c] && c < MAXC - 1) c++;
      e_en[c] = 1; e_mode[c] = 1;
      e_a[c] = N_LOG'(k); e_b[c] = N_LOG'(k); e_tw[c] = N_LOG'(N / 2 + k / 2);
      c++;
    end
    c += D;
`endif
    done_c = c;
  endtask

  function automatic logic [21:0] exp_vec(int n, int done_c);
    logic wea, web;
    logic [N_LOG-1:0] wa, wb;
    int m;
    m = n - D;
    wea = 0; web = 0; wa = '0; wb = '0;
    if (m >= 1) begin
      wea = e_en[m]; web = e_pair[m]; wa = e_a[m]; wb = e_b[m];
    end
    return {e_en[n], e_a[n], e_b[n], e_tw[n], e_mode[n], e_mode[n],
            wea, web, wa, wb, (n >= 1 && n < done_c), (n == done_c)};
  endfunction

  function automatic logic [21:0] obs_vec();
    return {bus.rd_en, bus.rd_addr_a, bus.rd_addr_b, bus.tw_index, bus.bf_mode, bus.bf_swap,
            bus.wr_en_a, bus.wr_en_b, bus.wr_addr_a, bus.wr_addr_b, bus.busy, bus.done};
  endfunction

  task automatic check_vec(input string tag, input logic [21:0] obs, input logic [21:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One transform; start sampled at edge 0, cycle n follows edge n-1.
  task automatic run(input int rst_cyc, input int repulse, input int want_done);
    int done_c, dut_done;
    logic [21:0] obs;
    build_model(done_c);
    dut_done = -1;
    @(negedge clk);
    check_vec("idle", obs_vec(), '0);
    bus.start = 1'b1;
    bus.stall = 1'b0;
    @(posedge clk);
    #1;
    for (int n = 1; n <= done_c + 2; n++) begin
      bus.stall = stall_pat[n];
      bus.start = (n == repulse);
      if (n == rst_cyc) begin
        reset = 1'b0;
        #1;
        check_vec("reset_now", obs_vec(), '0);
        repeat (3) begin
          @(negedge clk);
          check_vec("reset_hold", obs_vec(), '0);
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
        reset = 1'b1;
        return;
      end
      @(negedge clk);
      obs = obs_vec();
      if (obs[0] && dut_done < 0) dut_done = n;
      check_vec($sformatf("cycle%0d", n), obs, exp_vec(n, done_c));
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    bus.stall = 1'b0;
    if (want_done > 0) check_int("done_cycle", dut_done, want_done);
  endtask

  task automatic clear_stall();
    for (int i = 0; i < MAXC; i++) stall_pat[i] = 0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stall = 1'b0;
    clear_stall();
    repeat (3) @(negedge clk);
    check_vec("in_reset", obs_vec(), '0);
    reset = 1'b1;
    @(negedge clk);
    check_vec("after_reset", obs_vec(), '0);

    run(0, 0, 25 + PM_EXTRA);

    stall_pat[2] = 1; stall_pat[3] = 1;
    run(0, 0, 27 + PM_EXTRA);
    clear_stall();

    run(0, 5, 25 + PM_EXTRA);

    run(10, 0, -1);
    run(0, 0, 25 + PM_EXTRA);

    for (int r = 0; r < 4; r++) begin
      clear_stall();
      for (int c = 1; c < 60; c++) stall_pat[c] = ($urandom_range(3) == 0);
      run(0, 0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
